apb_master_ctrl: RTL
====================

// Module: apb_master_ctrl
//
// PURPOSE
//   Synthesisable, parametrised APB3 master: converts a valid/ready command stream into APB
//   transfers and returns one response per command. Adds pready wait states, pslverr, a
//   wait-state timeout and back-to-back transfers with no IDLE cycle. Sits between any
//   requester (bench sequencer, bridge, CPU port) and an APB slave such as a register block.
//
// PARAMETERS
//   ADDR_W   8   paddr / cmd_addr width in bits (>=1)
//   DATA_W   32  pwdata / prdata / data-path width in bits (8, 16 or 32)
//   TIMEOUT  16  max consecutive ACCESS cycles with pready=0 before abort; 0 = never abort
//
// PORTS
//   clk          in   1       clock, all logic on posedge
//   rst_n        in   1       asynchronous, active-low reset
//   cmd_valid    in   1       command offered
//   cmd_ready    out  1       command accepted when cmd_valid & cmd_ready at posedge
//   cmd_write    in   1       1 = write, 0 = read
//   cmd_addr     in   ADDR_W  transfer address
//   cmd_wdata    in   DATA_W  write data (ignored for reads)
//   rsp_valid    out  1       one-cycle pulse, one per accepted command, no backpressure
//   rsp_rdata    out  DATA_W  read data (0 for writes and on timeout)
//   rsp_err      out  1       pslverr sampled at completion, or timeout
//   rsp_timeout  out  1       completion was a timeout abort
//   psel         out  1       APB select
//   penable      out  1       APB enable
//   pwrite       out  1       APB direction
//   paddr        out  ADDR_W  APB address
//   pwdata       out  DATA_W  APB write data
//   prdata       in   DATA_W  APB read data
//   pready       in   1       APB slave ready
//   pslverr      in   1       APB slave error
//
// BEHAVIOUR
//   - Reset (async assert, sync deassert at the clk edge): state=IDLE; psel, penable, pwrite,
//     paddr, pwdata, rsp_* and the wait counter = 0. A transfer in flight is dropped and
//     produces no response.
//   - All APB and rsp_* outputs are registered. cmd_ready is combinational:
//     (state==IDLE) | (state==ACCESS & complete).
//   - FSM:
//     IDLE   -> SETUP on accept. psel=0, penable=0, pwrite/paddr/pwdata driven to 0.
//     SETUP  -> ACCESS unconditionally, after exactly 1 cycle. psel=1, penable=0, and
//               pwrite/paddr/pwdata = captured command.
//     ACCESS -> penable=1, psel=1, address/data held stable.
//               complete = pready | (TIMEOUT>0 & wait_cnt==TIMEOUT).
//               On complete: SETUP if a new command is accepted on the same edge (back-to-back:
//               psel stays 1, penable drops for one cycle), otherwise IDLE. No complete: stay.
//   - Wait counter: width $clog2(TIMEOUT+1). Clears on entering ACCESS; +1 on each ACCESS
//     cycle with pready=0; saturates.
//   - Response: on the completing edge, rsp_valid=1 in the next cycle only.
//     - Read with pready: rsp_rdata=prdata.
//     - Write: rsp_rdata=0.
//     - rsp_err=pslverr and rsp_timeout=0 when pready=1.
//     - Timeout: rsp_err=1, rsp_timeout=1, rsp_rdata=0, and pslverr/prdata are ignored.
//     - pready wins if it is high on the timeout cycle.
//   - pslverr and prdata are sampled only when psel & penable & pready.
//   - Minimum latency, accept to rsp_valid: 3 cycles (SETUP, ACCESS with pready=1, response).
//   - Throughput with back-to-back and zero wait states: one transfer per 2 cycles.
//   - cmd_* is sampled only on accept; changes while cmd_ready=0 are ignored.
//
// TESTING
//   1. Write A=0x10, D=0xDEADBEEF, pready=1 -> psel high 2 cycles, penable in cycle 2 only,
//      paddr/pwdata stable; rsp_valid 1 cycle later, rsp_err=0.
//   2. Read A=0x24, slave holds pready=0 for 3 ACCESS cycles then prdata=0x1234_5678 with
//      pready=1 -> penable high 4 cycles; rsp_rdata=0x12345678.
//   3. Two writes offered back-to-back, pready=1 -> psel never drops; penable sequence
//      0,1,0,1; second paddr appears in the cycle after the first ACCESS; 2 rsp_valid pulses.
//   4. Read with pready=1 and pslverr=1 -> rsp_err=1, rsp_timeout=0.
//   5. TIMEOUT=4 and pready held 0 -> abort after 4 wait cycles (5 ACCESS cycles), then IDLE;
//      rsp_err=1, rsp_timeout=1, rsp_rdata=0. With TIMEOUT=0 the bench must see no abort
//      after 1000 cycles.
//   6. Assert rst_n low mid-ACCESS -> psel/penable go 0 immediately (before the next clk
//      edge), no rsp_valid; the next command after release completes normally.

Source files
------------

// File: rtl/apb_master_ctrl.sv
// APB3 master: turns a valid/ready command stream into APB transfers, one response per command.
// Supports pready wait states, pslverr, optional wait-state timeout and back-to-back transfers.
module apb_master_ctrl #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    // Keep the counter at least one bit wide so TIMEOUT=0 still elaborates.
    localparam int unsigned      CntW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CntW-1:0] TimeoutCnt = CntW'(TIMEOUT);

    typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

    state_e          state_q;
    logic [CntW-1:0] wait_cnt_q;
    logic            timed_out;
    logic            complete;
    logic            accept;

    assign timed_out = (TIMEOUT > 0) && (wait_cnt_q == TimeoutCnt);
    assign complete  = (state_q == StAccess) && (pready || timed_out);
    assign cmd_ready = (state_q == StIdle) || complete;
    assign accept    = cmd_valid && cmd_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            wait_cnt_q  <= '0;
            psel        <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        psel    <= 1'b1;
                        pwrite  <= cmd_write;
                        paddr   <= cmd_addr;
                        pwdata  <= cmd_wdata;
                        state_q <= StSetup;
                    end
                end
                StSetup: begin
                    penable    <= 1'b1;
                    wait_cnt_q <= '0;
                    state_q    <= StAccess;
                end
                StAccess: begin
                    if (complete) begin
                        // pready has priority over a timeout landing on the same cycle.
                        rsp_valid   <= 1'b1;
                        rsp_timeout <= !pready;
                        rsp_err     <= pready ? pslverr : 1'b1;
                        rsp_rdata   <= (pready && !pwrite) ? prdata : '0;
                        penable     <= 1'b0;
                        if (accept) begin
                            pwrite  <= cmd_write;
                            paddr   <= cmd_addr;
                            pwdata  <= cmd_wdata;
                            state_q <= StSetup;
                        end else begin
                            psel    <= 1'b0;
                            pwrite  <= 1'b0;
                            paddr   <= '0;
                            pwdata  <= '0;
                            state_q <= StIdle;
                        end
                    end else if (wait_cnt_q != '1) begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
